// File: rtl/qbert_move_ctrl_pkg.sv
// Shared types and constants for the Qbert movement controller.
// Cube n = r(r+1)/2 + k on a 7-row pyramid; bit n of every 28-bit cube vector.
package qbert_pkg;

  localparam int N_CUBE = 28;
  localparam int N_ROW  = 7;

  localparam logic [2:0]        ROW_MAX = 3'(N_ROW - 1);
  localparam logic [N_CUBE-1:0] TOP     = 28'h0000001;
  // k = 0 edge and k = r edge; both include the top cube
  localparam logic [N_CUBE-1:0] RSIDE   = 28'h020844B;
  localparam logic [N_CUBE-1:0] LSIDE   = 28'h8104225;

  typedef enum logic [2:0] {
    DIR_NONE       = 3'b000,
    DIR_DOWN_RIGHT = 3'b001,
    DIR_DOWN_LEFT  = 3'b010,
    DIR_UP_RIGHT   = 3'b011,
    DIR_UP_LEFT    = 3'b100
  } dir_e;

  typedef enum logic [2:0] {
    LS_START  = 3'b000,
    LS_JUMP   = 3'b001,
    LS_IDLE   = 3'b010,
    LS_SAUCER = 3'b011,
    LS_KO     = 3'b100
  } layer_e;

  typedef enum logic [1:0] {
    ST_READY,
    ST_MOVING,
    ST_FALL
  } move_st_e;

  function automatic logic [N_CUBE-1:0] cube_onehot(input logic [2:0] row, input logic [2:0] col);
    logic [5:0]        r6;
    logic [5:0]        idx;
    logic [N_CUBE-1:0] one;
    r6  = {3'b000, row};
    idx = ((r6 * (r6 + 6'd1)) >> 1) + {3'b000, col};
    one = TOP;
    return one << idx;
  endfunction

endpackage

// File: rtl/qbert_move_ctrl_if.sv
// Jump command handshake between the input source and the movement controller.
interface qbert_move_ctrl_if;
  logic       cmd_valid;
  logic [2:0] cmd_dir;
  logic       cmd_ready;

  modport master (output cmd_valid, output cmd_dir, input  cmd_ready);
  modport slave  (input  cmd_valid, input  cmd_dir, output cmd_ready);
endinterface

// File: rtl/qbert_move_ctrl_pyramid_nav.sv
// Combinational neighbour lookup: current (row, col) plus direction gives the
// target cube and whether that target falls off the pyramid.
module pyramid_nav
  import qbert_pkg::*;
(
  input  logic [2:0]        row,
  input  logic [2:0]        col,
  input  dir_e              dir,
  output logic [2:0]        tgt_row,
  output logic [2:0]        tgt_col,
  output logic [N_CUBE-1:0] tgt_onehot,
  output logic              off_pyr
);

  logic [N_CUBE-1:0] here;

  assign here = cube_onehot(row, col);

  always_comb begin
    tgt_row = row;
    tgt_col = col;
    off_pyr = 1'b1;
    case (dir)
      DIR_DOWN_RIGHT: begin
        tgt_row = row + 3'd1;
        off_pyr = (row == ROW_MAX);
      end
      DIR_DOWN_LEFT: begin
        tgt_row = row + 3'd1;
        tgt_col = col + 3'd1;
        off_pyr = (row == ROW_MAX);
      end
      // upward moves fail exactly on the edge the move points away from
      DIR_UP_RIGHT: begin
        tgt_row = row - 3'd1;
        tgt_col = col - 3'd1;
        off_pyr = |(here & RSIDE);
      end
      DIR_UP_LEFT: begin
        tgt_row = row - 3'd1;
        off_pyr = |(here & LSIDE);
      end
      default: ;
    endcase
    tgt_onehot = off_pyr ? '0 : cube_onehot(tgt_row, tgt_col);
  end

endmodule

// File: rtl/qbert_move_ctrl.sv
// Qbert movement controller: accepts jump commands, tracks position and
// visited cubes, and sequences falls, saucer rides and restarts.
//   state     | meaning
//   ST_READY  | waiting for a command; e_next_qb equals position_qb
//   ST_MOVING | move issued, waiting for the done_move rising edge
//   ST_FALL   | jumped off the pyramid, waiting for the layer to show START
module qbert_move_ctrl
  import qbert_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              e_start_qb,
  qbert_move_ctrl_if.slave  cmd,
  input  logic              done_move,
  input  logic [2:0]        state_qb,
  output logic [N_CUBE-1:0] position_qb,
  output logic [N_CUBE-1:0] e_next_qb,
  output logic [2:0]        e_jump_qb,
  output logic              e_bad_jump,
  output logic [N_CUBE-1:0] cube_visited,
  output logic              all_visited
);

  move_st_e          fsm_q, fsm_d;
  logic [2:0]        row_q, row_d, col_q, col_d;
  logic [2:0]        nxt_row_q, nxt_row_d, nxt_col_q, nxt_col_d;
  logic [N_CUBE-1:0] e_next_q, e_next_d;
  dir_e              jump_q, jump_d;
  logic              bad_q, bad_d;
  logic [N_CUBE-1:0] visited_q, visited_d;
  logic              saucer_q, saucer_d;
  logic              done_prev_q, done_prev_d;
  logic              armed_q, armed_d;

  layer_e            layer;
  logic              cmd_legal, ready_c, accept, done_rise;
  logic [2:0]        nav_row, nav_col;
  logic [N_CUBE-1:0] nav_onehot;
  logic              nav_off;

  pyramid_nav u_nav (
    .row        (row_q),
    .col        (col_q),
    .dir        (dir_e'(cmd.cmd_dir)),
    .tgt_row    (nav_row),
    .tgt_col    (nav_col),
    .tgt_onehot (nav_onehot),
    .off_pyr    (nav_off)
  );

  assign layer     = layer_e'(state_qb);
  assign cmd_legal = (cmd.cmd_dir >= 3'd1) && (cmd.cmd_dir <= 3'd4);
  // armed_q keeps commands out until one full clock after reset release
  assign ready_c   = armed_q && (fsm_q == ST_READY) && !saucer_q
                     && (layer == LS_IDLE) && !e_start_qb;
  assign accept    = ready_c && cmd.cmd_valid && cmd_legal;
  assign done_rise = done_move && !done_prev_q;

  always_comb begin
    fsm_d       = fsm_q;
    row_d       = row_q;
    col_d       = col_q;
    nxt_row_d   = nxt_row_q;
    nxt_col_d   = nxt_col_q;
    e_next_d    = e_next_q;
    jump_d      = jump_q;
    bad_d       = bad_q;
    visited_d   = visited_q;
    saucer_d    = saucer_q;
    done_prev_d = done_move;
    armed_d     = 1'b1;

    if (e_start_qb) begin
      fsm_d     = ST_READY;
      row_d     = 3'd0;
      col_d     = 3'd0;
      nxt_row_d = 3'd0;
      nxt_col_d = 3'd0;
      e_next_d  = TOP;
      jump_d    = DIR_NONE;
      bad_d     = 1'b0;
      visited_d = TOP;
      saucer_d  = 1'b0;
    end else if (layer == LS_SAUCER) begin
      // drop the pending move and park the target on the current cube
      fsm_d     = ST_READY;
      jump_d    = DIR_NONE;
      bad_d     = 1'b0;
      nxt_row_d = row_q;
      nxt_col_d = col_q;
      e_next_d  = cube_onehot(row_q, col_q);
      saucer_d  = 1'b1;
    end else if (saucer_q) begin
      if (layer == LS_START) begin
        row_d     = 3'd0;
        col_d     = 3'd0;
        nxt_row_d = 3'd0;
        nxt_col_d = 3'd0;
        e_next_d  = TOP;
        saucer_d  = 1'b0;
      end
    end else begin
      case (fsm_q)
        ST_READY: begin
          if (accept) begin
            fsm_d     = ST_MOVING;
            jump_d    = dir_e'(cmd.cmd_dir);
            nxt_row_d = nav_row;
            nxt_col_d = nav_col;
            e_next_d  = nav_onehot;
            bad_d     = nav_off;
          end
        end
        ST_MOVING: begin
          if (done_rise) begin
            jump_d = DIR_NONE;
            if (bad_q) begin
              fsm_d = ST_FALL;
            end else begin
              fsm_d     = ST_READY;
              row_d     = nxt_row_q;
              col_d     = nxt_col_q;
              visited_d = visited_q | e_next_q;
            end
          end
        end
        ST_FALL: begin
          if (layer == LS_START) begin
            fsm_d     = ST_READY;
            row_d     = 3'd0;
            col_d     = 3'd0;
            nxt_row_d = 3'd0;
            nxt_col_d = 3'd0;
            e_next_d  = TOP;
            bad_d     = 1'b0;
          end
        end
        default: fsm_d = ST_READY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm_q       <= ST_READY;
      row_q       <= 3'd0;
      col_q       <= 3'd0;
      nxt_row_q   <= 3'd0;
      nxt_col_q   <= 3'd0;
      e_next_q    <= TOP;
      jump_q      <= DIR_NONE;
      bad_q       <= 1'b0;
      visited_q   <= TOP;
      saucer_q    <= 1'b0;
      done_prev_q <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      row_q       <= row_d;
      col_q       <= col_d;
      nxt_row_q   <= nxt_row_d;
      nxt_col_q   <= nxt_col_d;
      e_next_q    <= e_next_d;
      jump_q      <= jump_d;
      bad_q       <= bad_d;
      visited_q   <= visited_d;
      saucer_q    <= saucer_d;
      done_prev_q <= done_prev_d;
      armed_q     <= armed_d;
    end
  end

  assign cmd.cmd_ready = ready_c;
  assign position_qb   = cube_onehot(row_q, col_q);
  assign e_next_qb     = e_next_q;
  assign e_jump_qb     = jump_q;
  assign e_bad_jump    = bad_q;
  assign cube_visited  = visited_q;
  assign all_visited   = &visited_q;

endmodule

// File: tb/tb_qbert_move_ctrl.sv
// Bench for qbert_move_ctrl: cube-index reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_qbert_move_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        e_start_qb = 1'b0;
  logic        done_move = 1'b0;
  logic [2:0]  state_qb = 3'd2;
  logic [27:0] position_qb, e_next_qb, cube_visited;
  logic [2:0]  e_jump_qb;
  logic        e_bad_jump, all_visited;

  qbert_move_ctrl_if cif ();

  qbert_move_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .e_start_qb   (e_start_qb),
    .cmd          (cif.slave),
    .done_move    (done_move),
    .state_qb     (state_qb),
    .position_qb  (position_qb),
    .e_next_qb    (e_next_qb),
    .e_jump_qb    (e_jump_qb),
    .e_bad_jump   (e_bad_jump),
    .cube_visited (cube_visited),
    .all_visited  (all_visited)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // reference model: cube indices, row/column recovered arithmetically
  function automatic int row_of(input int n);
    int r = 0;
    while ((r + 1) * (r + 2) / 2 <= n) r++;
    return r;
  endfunction

  function automatic int target(input int n, input int d);
    int r, k, r2, k2;
    r = row_of(n);
    k = n - r * (r + 1) / 2;
    case (d)
      1: begin r2 = r + 1; k2 = k;     end
      2: begin r2 = r + 1; k2 = k + 1; end
      3: begin r2 = r - 1; k2 = k - 1; end
      4: begin r2 = r - 1; k2 = k;     end
      default: return -1;
    endcase
    if (r2 < 0 || r2 > 6 || k2 < 0 || k2 > r2) return -1;
    return r2 * (r2 + 1) / 2 + k2;
  endfunction

  function automatic logic [27:0] oh(input int n);
    logic [27:0] one;
    one = 28'h1;
    return (n < 0) ? 28'h0 : (one << n);
  endfunction

  int          m_pos = 0, m_tgt = 0, m_dir = 0, m_mode = 0;  // mode 0 ready, 1 moving, 2 fall
  bit          m_bad = 1'b0, m_saucer = 1'b0, m_prev = 1'b0, m_armed = 1'b0;
  logic [27:0] m_vis = 28'h1;
  logic        m_ready, m_rise, m_acc;

  assign m_ready = m_armed && (m_mode == 0) && !m_saucer && (state_qb == 3'd2) && !e_start_qb;
  assign m_rise  = done_move && !m_prev;
  assign m_acc   = m_ready && cif.cmd_valid && (cif.cmd_dir >= 3'd1) && (cif.cmd_dir <= 3'd4);

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_pos <= 0; m_tgt <= 0; m_dir <= 0; m_mode <= 0;
      m_bad <= 1'b0; m_saucer <= 1'b0; m_prev <= 1'b0; m_armed <= 1'b0;
      m_vis <= 28'h1;
    end else begin
      m_prev  <= done_move;
      m_armed <= 1'b1;
      if (e_start_qb) begin
        m_pos <= 0; m_tgt <= 0; m_dir <= 0; m_bad <= 1'b0;
        m_vis <= 28'h1; m_mode <= 0; m_saucer <= 1'b0;
      end else if (state_qb == 3'd3) begin
        m_dir <= 0; m_saucer <= 1'b1; m_mode <= 0; m_tgt <= m_pos; m_bad <= 1'b0;
      end else if (m_saucer) begin
        if (state_qb == 3'd0) begin
          m_pos <= 0; m_tgt <= 0; m_saucer <= 1'b0;
        end
      end else if (m_mode == 0) begin
        if (m_acc) begin
          m_dir  <= int'(cif.cmd_dir);
          m_tgt  <= target(m_pos, int'(cif.cmd_dir));
          m_bad  <= (target(m_pos, int'(cif.cmd_dir)) < 0);
          m_mode <= 1;
        end
      end else if (m_mode == 1) begin
        if (m_rise) begin
          m_dir <= 0;
          if (m_bad) m_mode <= 2;
          else begin
            m_pos  <= m_tgt;
            m_vis  <= m_vis | oh(m_tgt);
            m_mode <= 0;
          end
        end
      end else if (state_qb == 3'd0) begin
        m_pos <= 0; m_tgt <= 0; m_bad <= 1'b0; m_mode <= 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_position", 64'(position_qb), 64'(oh(m_pos)));
      chk("m_e_next", 64'(e_next_qb), 64'(oh(m_tgt)));
      chk("m_e_jump", 64'(e_jump_qb), 64'(m_dir));
      chk("m_bad_jump", 64'(e_bad_jump), 64'(m_bad));
      chk("m_visited", 64'(cube_visited), 64'(m_vis));
      chk("m_all_visited", 64'(all_visited), 64'(&m_vis));
      chk("m_cmd_ready", 64'(cif.cmd_ready), 64'(m_ready));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_move(input logic [2:0] d);
    state_qb = 3'd2; cif.cmd_valid = 1'b1; cif.cmd_dir = d;
    tick();
    cif.cmd_valid = 1'b0; state_qb = 3'd1;
    tick();
    done_move = 1'b1;
    tick();
    done_move = 1'b0; state_qb = 3'd2;
    tick();
  endtask

  // column-by-column tour that touches all 28 cubes, ending on cube 27
  int path [30] = '{1,1,1,1,1,1,4,2,4,4,4,4,4,2,1,1,1,1,4,2,4,4,4,2,1,1,4,2,4,2};

  initial begin
    cif.cmd_valid = 1'b0;
    cif.cmd_dir   = 3'd0;
    tick(); tick();
    chk_en = 1'b1;
    tick();
    chk("rst_pos",   64'(position_qb), 64'h1);
    chk("rst_next",  64'(e_next_qb), 64'h1);
    chk("rst_vis",   64'(cube_visited), 64'h1);
    chk("rst_all",   64'(all_visited), 64'h0);
    chk("rst_jump",  64'(e_jump_qb), 64'h0);
    chk("rst_bad",   64'(e_bad_jump), 64'h0);
    chk("rst_ready", 64'(cif.cmd_ready), 64'h0);

    // command held from release: ignored on first clock, taken on second
    reset = 1'b1; cif.cmd_valid = 1'b1; cif.cmd_dir = 3'd1;
    tick();
    chk("early_cmd", 64'(e_jump_qb), 64'h0);
    tick();
    cif.cmd_valid = 1'b0;
    chk("first_jump", 64'(e_jump_qb), 64'h1);
    chk("first_next", 64'(e_next_qb), 64'h2);

    state_qb = 3'd1; cif.cmd_valid = 1'b1; cif.cmd_dir = 3'd2;
    #1;
    chk("busy_ready", 64'(cif.cmd_ready), 64'h0);
    tick();
    cif.cmd_valid = 1'b0;
    chk("busy_jump", 64'(e_jump_qb), 64'h1);
    chk("busy_next", 64'(e_next_qb), 64'h2);
    done_move = 1'b1;
    tick();
    done_move = 1'b0; state_qb = 3'd2;
    chk("land_pos",  64'(position_qb), 64'h2);
    chk("land_vis",  64'(cube_visited), 64'h3);
    chk("land_jump", 64'(e_jump_qb), 64'h0);
    chk("land_next", 64'(e_next_qb), 64'h2);
    tick();

    cif.cmd_valid = 1'b1; cif.cmd_dir = 3'b111;
    tick();
    cif.cmd_valid = 1'b0;
    chk("illegal_jump", 64'(e_jump_qb), 64'h0);
    chk("illegal_next", 64'(e_next_qb), 64'h2);

    done_move = 1'b1;
    tick();
    done_move = 1'b0;
    tick();
    chk("stray_done_pos", 64'(position_qb), 64'h2);

    state_qb = 3'd1; cif.cmd_valid = 1'b1; cif.cmd_dir = 3'd1;
    tick();
    cif.cmd_valid = 1'b0; state_qb = 3'd2;
    chk("not_idle_jump", 64'(e_jump_qb), 64'h0);

    // off the top, fall, respawn
    e_start_qb = 1'b1;
    tick();
    e_start_qb = 1'b0;
    chk("restart_pos", 64'(position_qb), 64'h1);
    chk("restart_vis", 64'(cube_visited), 64'h1);
    cif.cmd_valid = 1'b1; cif.cmd_dir = 3'd4;
    tick();
    cif.cmd_valid = 1'b0;
    chk("off_next", 64'(e_next_qb), 64'h0);
    chk("off_bad",  64'(e_bad_jump), 64'h1);
    state_qb = 3'd1;
    tick();
    done_move = 1'b1;
    tick();
    done_move = 1'b0; state_qb = 3'd4;
    chk("fall_jump", 64'(e_jump_qb), 64'h0);
    chk("fall_bad",  64'(e_bad_jump), 64'h1);
    tick(); tick();
    chk("fall_hold_bad", 64'(e_bad_jump), 64'h1);
    state_qb = 3'd0;
    tick();
    state_qb = 3'd2;
    chk("fall_pos",  64'(position_qb), 64'h1);
    chk("fall_bad0", 64'(e_bad_jump), 64'h0);
    chk("fall_next", 64'(e_next_qb), 64'h1);
    tick();

    // saucer aborts a pending move, START returns to the top
    do_move(3'd1);
    cif.cmd_valid = 1'b1; cif.cmd_dir = 3'd2;
    tick();
    cif.cmd_valid = 1'b0;
    chk("sauc_next", 64'(e_next_qb), 64'h10);
    state_qb = 3'd3;
    tick();
    chk("sauc_jump", 64'(e_jump_qb), 64'h0);
    state_qb = 3'd0;
    tick();
    state_qb = 3'd2;
    chk("sauc_pos", 64'(position_qb), 64'h1);
    tick();

    e_start_qb = 1'b1;
    tick();
    e_start_qb = 1'b0;
    for (int i = 0; i < 30; i++) begin
      do_move(3'(path[i]));
      if (i == 28) chk("pre_all", 64'(all_visited), 64'h0);
    end
    chk("tour_all",  64'(all_visited), 64'h1);
    chk("tour_vis",  64'(cube_visited), 64'hFFFFFFF);
    chk("tour_pos",  64'(position_qb), 64'h8000000);

    cif.cmd_valid = 1'b1; cif.cmd_dir = 3'd2;
    tick();
    cif.cmd_valid = 1'b0;
    chk("c27_bad",  64'(e_bad_jump), 64'h1);
    chk("c27_next", 64'(e_next_qb), 64'h0);
    e_start_qb = 1'b1;
    tick();
    e_start_qb = 1'b0;
    chk("rs_vis",  64'(cube_visited), 64'h1);
    chk("rs_all",  64'(all_visited), 64'h0);
    chk("rs_bad",  64'(e_bad_jump), 64'h0);
    chk("rs_jump", 64'(e_jump_qb), 64'h0);
    chk("rs_pos",  64'(position_qb), 64'h1);
    tick();

    repeat (6) do_move(3'd1);
    chk("c21_pos", 64'(position_qb), 64'h200000);
    cif.cmd_valid = 1'b1; cif.cmd_dir = 3'd3;
    tick();
    cif.cmd_valid = 1'b0;
    chk("c21_bad",  64'(e_bad_jump), 64'h1);
    chk("c21_next", 64'(e_next_qb), 64'h0);

    // asynchronous reset while moving, then a late done pulse
    reset = 1'b0;
    #1;
    chk("mid_rst_pos",  64'(position_qb), 64'h1);
    chk("mid_rst_next", 64'(e_next_qb), 64'h1);
    chk("mid_rst_bad",  64'(e_bad_jump), 64'h0);
    chk("mid_rst_jump", 64'(e_jump_qb), 64'h0);
    chk("mid_rst_vis",  64'(cube_visited), 64'h1);
    tick();
    reset = 1'b1; done_move = 1'b1;
    tick();
    done_move = 1'b0;
    tick();
    chk("post_rst_pos",  64'(position_qb), 64'h1);
    chk("post_rst_jump", 64'(e_jump_qb), 64'h0);
    chk("post_rst_vis",  64'(cube_visited), 64'h1);
    tick();

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/qbert_move_ctrl.md
QBERT_MOVE_CTRL -- requirements
Module: qbert_move_ctrl

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-low reset.
REQ-003 e_start_qb  input  1  game restart pulse; synchronous re-init to TOP.
REQ-004 cmd_valid  input  1  jump request qualifier, one cycle.
REQ-005 cmd_dir  input  3  direction: 001 DOWN_RIGHT, 010 DOWN_LEFT, 011 UP_RIGHT, 100 UP_LEFT; others illegal.
REQ-006 cmd_ready  output  1  high when a command is accepted this cycle.
REQ-007 done_move  input  1  move-complete flag from the Qbert layer.
REQ-008 state_qb  input  3  Qbert layer state: 000 START, 001 JUMP, 010 IDLE, 011 SAUCER, 100 KO.
REQ-009 position_qb  output  28  one-hot current cube.
REQ-010 e_next_qb  output  28  one-hot target cube; 0 when the target is off-pyramid.
REQ-011 e_jump_qb  output  3  direction held for the layer; 000 when no move is pending.
REQ-012 e_bad_jump  output  1  pending or last move leaves the pyramid.
REQ-013 cube_visited  output  28  one bit per cube, set on landing.
REQ-014 all_visited  output  1  cube_visited == all ones.

Function
REQ-015 Cube n = r(r+1)/2 + k, row r 0..6, column k 0..r; bit n of the 28-bit vector.
REQ-016 Targets:
- DOWN_RIGHT (r+1,k)
- DOWN_LEFT (r+1,k+1)
- UP_RIGHT (r-1,k-1)
- UP_LEFT (r-1,k)
REQ-017 A target is off-pyramid if r+1>6, r-1<0, k-1<0 or k>r; then e_next_qb=0 and e_bad_jump=1.
REQ-018 FSM states: READY, MOVING, FALL.
REQ-019 READY: cmd_ready = state_qb==IDLE and no pending move. A cmd_valid with legal cmd_dir is accepted in the same cycle. Next cycle e_jump_qb=cmd_dir, e_next_qb/e_bad_jump valid, state MOVING.
REQ-020 An illegal cmd_dir, or cmd_valid while cmd_ready=0, is dropped: no output changes, no queueing.
REQ-021 MOVING: outputs held stable. On the rising edge of done_move (registered previous value 0, current 1):
- good move: position_qb<=e_next_qb, set that cube_visited bit, e_jump_qb<=000, e_next_qb<=e_next value, go READY.
- bad move: go FALL, e_jump_qb<=000.
REQ-022 FALL: hold e_bad_jump=1 until state_qb==START is observed. Then position_qb<=TOP (bit 0), e_next_qb<=TOP, e_bad_jump<=0, go READY. cube_visited is kept.
REQ-023 state_qb==SAUCER in any state: abort the pending move (e_jump_qb<=000). On the following START: position_qb<=TOP, e_next_qb<=TOP, go READY.
REQ-024 e_start_qb has priority over all events. Next cycle: position_qb=e_next_qb=TOP, cube_visited=1 (bit 0 only), e_jump_qb=0, e_bad_jump=0, state READY.
REQ-025 In READY, e_next_qb==position_qb, so the layer never leaves IDLE spuriously.
REQ-026 position_qb is always exactly one-hot. A done_move edge outside MOVING is ignored.

Reset
REQ-027 While reset=0:
- position_qb=28'h1, e_next_qb=28'h1
- e_jump_qb=0, e_bad_jump=0
- cube_visited=28'h1, all_visited=0
- cmd_ready=0, FSM=READY, done_move edge register=0.
REQ-028 Reset assertion mid-move aborts the move immediately. The first command is accepted no earlier than the second clock after release.

Structure
REQ-029 Shared package qbert_pkg holds:
- direction enum (NONE, DOWN_RIGHT, DOWN_LEFT, UP_RIGHT, UP_LEFT)
- layer state enum (START..KO)
- TOP constant, Rside and Lside masks (k=0 and k=r cubes)
- N_CUBE=28, N_ROW=7.
REQ-030 One combinational sub-module, pyramid_nav: (row, col, dir) -> (target one-hot, off-pyramid flag). Row/column are held internally as 3-bit registers; the one-hot output is derived from them.

Verification
REQ-031 From reset, state_qb=IDLE, cmd DOWN_RIGHT -> next cycle e_jump_qb=001, e_next_qb=28'h2; done_move rise -> position_qb=28'h2, cube_visited=28'h3.
REQ-032 At TOP, cmd UP_LEFT -> e_next_qb=0, e_bad_jump=1; done_move rise -> FALL; state_qb=START -> position_qb=28'h1, e_bad_jump=0.
REQ-033 At cube 27 (r6,k6), cmd DOWN_LEFT -> e_bad_jump=1. At cube 21 (r6,k0), cmd UP_RIGHT -> e_bad_jump=1.
REQ-034 cmd_valid while state_qb=JUMP or during MOVING -> cmd_ready=0, outputs unchanged; a second cmd_valid in the same move is dropped.
REQ-035 Visit all 28 cubes by a legal path -> all_visited=1 on the final commit; then e_start_qb -> cube_visited=28'h1, all_visited=0.
REQ-036 Assert reset during MOVING, release -> all outputs equal the REQ-027 values; a done_move pulse arriving after release is ignored.
